// File: rtl/cnnip_pkg.sv
// Shared types and parameter helpers for the cnnip stream blocks.
package cnnip_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EMIT  = 2'd2
    } unpack_state_e;

    // Number of SUBW-wide elements packed into one WIDTH-wide FIFO word.
    function automatic int lanes_of(input int width, input int subw);
        return width / subw;
    endfunction

    // Lane index width; LANES >= 2 keeps this at least one bit.
    function automatic int lane_w_of(input int width, input int subw);
        return $clog2(width / subw);
    endfunction

endpackage

// File: rtl/cnnip_word_unpacker_if.sv
// FIFO read port plus element stream seen by the word unpacker.
interface cnnip_word_unpacker_if #(
    parameter int WIDTH = 32,
    parameter int SUBW  = 8
);
    logic             fifo_empty_a;
    logic             fifo_pop_a;
    logic [WIDTH-1:0] fifo_dout_a;
    logic             m_valid_a;
    logic             m_ready_a;
    logic [SUBW-1:0]  m_data_a;
    logic             m_last_a;

    modport master (
        input  fifo_empty_a, fifo_dout_a, m_ready_a,
        output fifo_pop_a, m_valid_a, m_data_a, m_last_a
    );

    modport slave (
        output fifo_empty_a, fifo_dout_a, m_ready_a,
        input  fifo_pop_a, m_valid_a, m_data_a, m_last_a
    );
endinterface

// File: rtl/cnnip_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two.
module cnnip_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_a,
    input  logic             arst_aq,
    input  logic             push_a,
    input  logic [WIDTH-1:0] din_a,
    input  logic             pop_a,
    output logic [WIDTH-1:0] dout_a,
    output logic             empty_a,
    output logic             full_a
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_a = (count_q == '0);
    assign full_a  = (count_q == (AW+1)'(DEPTH));
    assign do_push = push_a && !full_a;
    assign do_pop  = pop_a && !empty_a;
    assign dout_a  = mem[rd_ptr_q];

    always_ff @(posedge clk_a or posedge arst_aq) begin
        if (arst_aq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk_a) begin
        if (do_push) mem[wr_ptr_q] <= din_a;
    end

endmodule

// File: rtl/cnnip_word_unpacker.sv
// Splits FIFO words into LSB-first SUBW-wide elements of a length-counted frame.
module cnnip_word_unpacker
    import cnnip_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SUBW  = 8,
    parameter int LENW  = 16
) (
    input  logic            clk_a,
    input  logic            arst_aq,
    input  logic            start_a,
    input  logic [LENW-1:0] frame_len_a,
    output logic            busy_a,
    output logic            done_a,
    cnnip_word_unpacker_if.master bus
);
    localparam int LANES  = lanes_of(WIDTH, SUBW);
    localparam int LANE_W = lane_w_of(WIDTH, SUBW);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [LANE_W-1:0] LANE_ONE  = LANE_W'(1);
    localparam logic [LENW-1:0]   CNT_ONE   = LENW'(1);

    unpack_state_e     state_q, state_d;
    logic [LENW-1:0]   len_q, len_d;
    logic [LENW-1:0]   cnt_q, cnt_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              done_q, done_d;

    logic              valid;
    logic              last;
    logic              hs;
    logic              pop;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_a or posedge arst_aq) begin
        if (arst_aq) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    assign valid = (state_q == EMIT);
    assign last  = valid && (cnt_q == (len_q - CNT_ONE));
    assign hs    = valid && bus.m_ready_a;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        word_d  = word_q;
        done_d  = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_a) begin
                    len_d = frame_len_a;
                    cnt_d = '0;
                    if (frame_len_a == '0) done_d  = 1'b1;
                    else                   state_d = FETCH;
                end
            end
            FETCH: begin
                if (!bus.fifo_empty_a) begin
                    pop     = 1'b1;
                    word_d  = bus.fifo_dout_a;
                    lane_d  = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (hs) begin
                    cnt_d  = cnt_q + CNT_ONE;
                    lane_d = lane_q + LANE_ONE;
                    if (last) begin
                        // Remaining lanes of this word are dropped with the frame.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (lane_q == LAST_LANE) begin
                        lane_d = '0;
                        if (!bus.fifo_empty_a) begin
                            pop    = 1'b1;
                            word_d = bus.fifo_dout_a;
                        end else begin
                            state_d = FETCH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_a         = (state_q != IDLE);
    assign done_a         = done_q;
    assign bus.fifo_pop_a = pop;
    assign bus.m_valid_a  = valid;
    assign bus.m_last_a   = last;
    assign bus.m_data_a   = valid ? word_q[int'(lane_q) * SUBW +: SUBW] : '0;

endmodule

// File: doc/cnnip_word_unpacker.md
CNNIP_WORD_UNPACKER -- requirements
Module: cnnip_word_unpacker

Interface
REQ-001 SHALL have parameter WIDTH, default 32: FIFO word width.
REQ-002 SHALL have parameter SUBW, default 8: output element width; WIDTH SHALL be an integer multiple of SUBW, LANES = WIDTH/SUBW >= 2.
REQ-003 SHALL have parameter LENW, default 16: width of the frame length count.
REQ-004 SHALL have port clk_a, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port arst_aq, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port start_a, input, 1: frame start request, sampled in IDLE only.
REQ-007 SHALL have port frame_len_a, input, LENW: number of elements in the frame, sampled with start_a.
REQ-008 SHALL have port busy_a, output, 1: high whenever state is not IDLE.
REQ-009 SHALL have port done_a, output, 1: one-cycle frame-complete pulse.
REQ-010 SHALL have port fifo_empty_a, input, 1: empty flag of the upstream single-clock FIFO.
REQ-011 SHALL have port fifo_pop_a, output, 1: pop to the upstream FIFO.
REQ-012 SHALL have port fifo_dout_a, input, WIDTH: head word of the upstream FIFO, valid while not empty.
REQ-013 SHALL have port m_valid_a, output, 1: element valid.
REQ-014 SHALL have port m_ready_a, input, 1: downstream ready.
REQ-015 SHALL have port m_data_a, output, SUBW: element data.
REQ-016 SHALL have port m_last_a, output, 1: marks the final element of the frame.

Function
REQ-017 The FSM SHALL have the states IDLE, FETCH and EMIT.
REQ-018 In IDLE with start_a=1, the block SHALL latch frame_len_a and clear the element counter; with length 0 it SHALL stay in IDLE and pulse done_a on the next cycle; otherwise it SHALL go to FETCH.
REQ-019 start_a SHALL be ignored outside IDLE.
REQ-020 In FETCH, fifo_pop_a SHALL equal !fifo_empty_a.
REQ-021 On a FETCH pop, the block SHALL capture fifo_dout_a into the word register, set lane to 0 and go to EMIT.
REQ-022 fifo_pop_a SHALL never assert while fifo_empty_a=1.
REQ-023 In EMIT, m_valid_a SHALL be 1 and m_data_a SHALL equal word[lane*SUBW +: SUBW]; lane 0 is the LSBs.
REQ-024 m_last_a SHALL be high when counter == len-1; it is valid only while m_valid_a is high.
REQ-025 A handshake SHALL occur when m_valid_a and m_ready_a are both high; on each handshake the counter and lane SHALL increment.
REQ-026 While m_valid_a=1 and m_ready_a=0, m_data_a and m_last_a SHALL be held stable.
REQ-027 A handshake with m_last_a=1 SHALL return the FSM to IDLE and pulse done_a in the following cycle; unconsumed lanes of the current word SHALL be discarded and no further pop issued.
REQ-028 A non-last handshake on lane LANES-1 with fifo_empty_a=0 SHALL pop in the same cycle, reload the word and stay in EMIT (no bubble).
REQ-029 A non-last handshake on lane LANES-1 with fifo_empty_a=1 SHALL go to FETCH with m_valid_a low.
REQ-030 Throughput SHALL be 1 element/cycle with continuous ready and a non-empty FIFO.
REQ-031 The first element SHALL appear 1 cycle after the FETCH pop (the registered word).
REQ-032 The counter SHALL be LENW bits and SHALL never wrap within a frame.

Reset
REQ-033 While arst_aq=1, the block SHALL be in IDLE with busy_a=0, done_a=0, fifo_pop_a=0, m_valid_a=0, m_last_a=0, m_data_a=0, counter=0 and lane=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately: the partial word is lost, no done_a pulse is produced, and the FIFO is not reset by this block.

Structure
REQ-035 The FSM state enum and the LANES/lane-index width derivation SHALL reside in the shared package cnnip_pkg.
REQ-036 There SHALL be no sub-modules; the lane mux SHALL be inline.
REQ-037 Benches SHALL instantiate the block directly downstream of cnnip_fifo (WIDTH=32, DEPTH=4).

Verification
REQ-038 Scenario, burst: FIFO preloaded with 0x44332211 and 0x88776655, len=8, ready=1 -> m_data 11,22,...,88 on 8 consecutive cycles, m_last on 0x88, done_a 1 cycle later, 2 pops total.
REQ-039 Scenario, partial word: same preload, len=5 -> 11..55 emitted, m_last on 0x55, word 2 lanes 1-3 discarded, FIFO empty afterwards.
REQ-040 Scenario, backpressure: ready toggling 1,0,0,1 per cycle -> m_data held during ready=0, no element dropped or duplicated, order preserved.
REQ-041 Scenario, starvation: FIFO empty after the first word, len=8 -> m_valid_a low in FETCH, no pop while empty, resumes when a push arrives, last element correct.
REQ-042 Scenario, zero length: start with len=0 -> no pop, no m_valid_a, done_a pulse 1 cycle later.
REQ-043 Scenario, mid-frame reset: arst_aq pulsed after 3 elements -> all outputs at reset values, a new start with len=4 completes normally from the next FIFO word.
